// File: rtl/cache_lookup_engine.sv
// Sequential key search over a memory_block read port: one entry per cycle, early exit on hit,
// lowest free slot reported on a miss. Optional macro: LOOKUP_TTL_EXPIRE_EN (TTL==0 means expired).
module cache_lookup_engine #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32,
    parameter int ADDR_WIDTH  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [KEY_WIDTH-1:0]   req_key,
    output logic [ADDR_WIDTH-1:0]  mem_read_addr,
    input  logic [KEY_WIDTH-1:0]   mem_key,
    input  logic [VALUE_WIDTH-1:0] mem_value,
    input  logic [TTL_WIDTH-1:0]   mem_ttl,
    input  logic                   mem_valid,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [ADDR_WIDTH-1:0]  resp_idx,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic [TTL_WIDTH-1:0]   resp_ttl,
    output logic                   resp_free_valid,
    output logic [ADDR_WIDTH-1:0]  resp_free_idx,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_ENTRIES - 1);

    state_t                 state, state_next;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [ADDR_WIDTH-1:0]  scan_addr;
    logic [ADDR_WIDTH-1:0]  free_idx;
    logic                   free_found;
    logic                   match;
    logic                   slot_free;
    logic                   last;

`ifdef LOOKUP_TTL_EXPIRE_EN
    logic expired;
    assign expired   = mem_valid && (mem_ttl == '0);
    assign slot_free = !mem_valid || expired;
    assign match     = mem_valid && !expired && (mem_key == key_q);
`else
    assign slot_free = !mem_valid;
    assign match     = mem_valid && (mem_key == key_q);
`endif

    assign last          = (scan_addr == LAST);
    assign req_ready     = (state == IDLE);
    assign busy          = !req_ready;
    assign resp_valid    = (state == DONE);
    // Read port parks at 0 outside a scan so the memory sees a quiet address
    assign mem_read_addr = (state == SCAN) ? scan_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = SCAN;
            SCAN:    if (match || last) state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q           <= '0;
            scan_addr       <= '0;
            free_idx        <= '0;
            free_found      <= 1'b0;
            resp_hit        <= 1'b0;
            resp_idx        <= '0;
            resp_value      <= '0;
            resp_ttl        <= '0;
            resp_free_valid <= 1'b0;
            resp_free_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key_q      <= req_key;
                        scan_addr  <= '0;
                        free_idx   <= '0;
                        free_found <= 1'b0;
                    end
                end
                SCAN: begin
                    if (match) begin
                        resp_hit        <= 1'b1;
                        resp_idx        <= scan_addr;
                        resp_value      <= mem_value;
                        resp_ttl        <= mem_ttl;
                        resp_free_valid <= 1'b0;
                        resp_free_idx   <= '0;
                    end else begin
                        if (slot_free && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= scan_addr;
                        end
                        if (last) begin
                            // The final entry's free status is folded in directly: the tracker
                            // update above lands on the same edge.
                            resp_hit        <= 1'b0;
                            resp_idx        <= '0;
                            resp_value      <= '0;
                            resp_ttl        <= '0;
                            resp_free_valid <= free_found || slot_free;
                            resp_free_idx   <= free_found ? free_idx :
                                               (slot_free ? scan_addr : '0);
                        end else begin
                            scan_addr <= scan_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        scan_addr       <= '0;
                        resp_hit        <= 1'b0;
                        resp_idx        <= '0;
                        resp_value      <= '0;
                        resp_ttl        <= '0;
                        resp_free_valid <= 1'b0;
                        resp_free_idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lookup_engine.sv
// Directed bench for cache_lookup_engine with a combinational 16-entry memory model.
module tb_cache_lookup_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_hit, resp_free_valid, busy;
    logic        mem_valid;
    logic [63:0] req_key, mem_key, mem_value, resp_value;
    logic [31:0] mem_ttl, resp_ttl;
    logic [3:0]  mem_read_addr, resp_idx, resp_free_idx;

    logic [63:0] mkey [16];
    logic [63:0] mval [16];
    logic [31:0] mttl [16];
    logic        mvld [16];

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    always #5 clk = ~clk;

    assign mem_key   = mkey[mem_read_addr];
    assign mem_value = mval[mem_read_addr];
    assign mem_ttl   = mttl[mem_read_addr];
    assign mem_valid = mvld[mem_read_addr];

    cache_lookup_engine dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .mem_read_addr(mem_read_addr), .mem_key(mem_key), .mem_value(mem_value),
        .mem_ttl(mem_ttl), .mem_valid(mem_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_idx(resp_idx), .resp_value(resp_value), .resp_ttl(resp_ttl),
        .resp_free_valid(resp_free_valid), .resp_free_idx(resp_free_idx), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            mkey[i] = 64'h0; mval[i] = 64'h0; mttl[i] = 32'h0; mvld[i] = 1'b0;
        end
    endtask

    task automatic put(input int i, input logic [63:0] k, input logic [63:0] v, input logic [31:0] t);
        mkey[i] = k; mval[i] = v; mttl[i] = t; mvld[i] = 1'b1;
    endtask

    // Presents a request; lat counts edges with the accepting edge as 1, ending at the edge
    // after which resp_valid is seen.
    task automatic lookup(input logic [63:0] key);
        @(negedge clk);
        req_key = key; req_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!resp_valid) chk("resp_timeout", 64'(resp_valid), 64'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("consume_resp_valid", 64'(resp_valid), 64'd0);
        chk("consume_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_key = 64'h0;
        clear_table();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_read_addr", 64'(mem_read_addr), 64'd0);
        rst_n = 1'b1;

        // 1: empty table miss
        lookup(64'hA5);
        chk("t1_lat", 64'(lat), 64'd17);
        chk("t1_hit", 64'(resp_hit), 64'd0);
        chk("t1_free_valid", 64'(resp_free_valid), 64'd1);
        chk("t1_free_idx", 64'(resp_free_idx), 64'd0);
        chk("t1_value", resp_value, 64'd0);
        consume();

        // 2: hit at idx 5
        put(5, 64'h1234, 64'hBEEF, 32'd100);
        lookup(64'h1234);
        chk("t2_lat", 64'(lat), 64'd7);
        chk("t2_hit", 64'(resp_hit), 64'd1);
        chk("t2_idx", 64'(resp_idx), 64'd5);
        chk("t2_value", resp_value, 64'hBEEF);
        chk("t2_ttl", 64'(resp_ttl), 64'd100);
        chk("t2_free_valid", 64'(resp_free_valid), 64'd0);
        consume();

        // 3: full table miss, then only idx 3 free
        for (int i = 0; i < 16; i++) put(i, 64'h1000 + 64'(i), 64'(i), 32'd9);
        lookup(64'hDEAD);
        chk("t3_lat", 64'(lat), 64'd17);
        chk("t3_hit", 64'(resp_hit), 64'd0);
        chk("t3_free_valid", 64'(resp_free_valid), 64'd0);
        chk("t3_free_idx", 64'(resp_free_idx), 64'd0);
        consume();
        mvld[3] = 1'b0;
        lookup(64'hDEAD);
        chk("t3b_free_valid", 64'(resp_free_valid), 64'd1);
        chk("t3b_free_idx", 64'(resp_free_idx), 64'd3);
        consume();
        mvld[15] = 1'b0; mvld[3] = 1'b1;
        lookup(64'hDEAD);
        chk("t3c_free_idx_last", 64'(resp_free_idx), 64'd15);
        consume();

        // 4: duplicate keys, lowest index wins; response held under backpressure
        clear_table();
        put(2, 64'h55, 64'h22, 32'd2);
        put(9, 64'h55, 64'h99, 32'd9);
        lookup(64'h55);
        chk("t4_lat", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_hold_valid", 64'(resp_valid), 64'd1);
            chk("t4_hold_idx", 64'(resp_idx), 64'd2);
            chk("t4_hold_value", resp_value, 64'h22);
            chk("t4_hold_req_ready", 64'(req_ready), 64'd0);
            chk("t4_hold_busy", 64'(busy), 64'd1);
        end
        consume();

        // 5: reset mid-scan at scan_addr 7
        clear_table();
        @(negedge clk);
        req_key = 64'h77; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (mem_read_addr != 4'd7 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("t5_reached_7", 64'(mem_read_addr), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("t5_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_read_addr", 64'(mem_read_addr), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        put(1, 64'h77, 64'h7, 32'd3);
        lookup(64'h77);
        chk("t5_after_lat", 64'(lat), 64'd3);
        chk("t5_after_idx", 64'(resp_idx), 64'd1);
        chk("t5_after_hit", 64'(resp_hit), 64'd1);
        consume();

        // 6: zero-TTL entry at idx 4, everything else valid
        for (int i = 0; i < 16; i++) put(i, 64'h2000 + 64'(i), 64'(i), 32'd5);
        put(4, 64'h77, 64'h44, 32'd0);
        lookup(64'h77);
`ifdef LOOKUP_TTL_EXPIRE_EN
        chk("t6_hit", 64'(resp_hit), 64'd0);
        chk("t6_free_valid", 64'(resp_free_valid), 64'd1);
        chk("t6_free_idx", 64'(resp_free_idx), 64'd4);
        chk("t6_lat", 64'(lat), 64'd17);
`else
        chk("t6_hit", 64'(resp_hit), 64'd1);
        chk("t6_idx", 64'(resp_idx), 64'd4);
        chk("t6_value", resp_value, 64'h44);
        chk("t6_lat", 64'(lat), 64'd6);
`endif
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
